// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered results, signed-overflow flag,
// and optional iterative MUL/DIVU/REMU that take one step per cycle.
module alu_seq #(
    parameter int unsigned WIDTH         = 64,
    parameter bit          ENABLE_MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             OutValid,
    input  logic             OutReady
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Iterative datapath registers: op_a is multiplicand / dividend-quotient
    // shifter, op_b is multiplier / divisor, acc is product / partial remainder.
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;
    logic [3:0]       op_q;

    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             ovf_d;
    logic             in_ready_d;
    logic             out_valid_d;

    logic             is_iter_c;
    logic             accept_c;
    logic             last_step_c;

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] diff_c;
    logic [SHW-1:0]   shamt_c;
    logic             slt_c;
    logic             sltu_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_ovf_c;

    logic [WIDTH-1:0] mul_acc_next_c;
    logic [WIDTH:0]   div_shift_c;
    logic             div_ge_c;
    logic [WIDTH-1:0] div_sub_c;
    logic [WIDTH-1:0] div_rem_next_c;
    logic [WIDTH-1:0] div_q_next_c;
    logic [WIDTH-1:0] iter_res_c;

    assign is_iter_c   = ENABLE_MULDIV &&
                         ((ALUControl == OP_MUL) || (ALUControl == OP_DIVU) ||
                          (ALUControl == OP_REMU));
    assign accept_c    = (state == IDLE) && InValid;
    assign last_step_c = (cnt_q == SHW'(WIDTH - 1));

    assign sum_c   = A + B;
    assign diff_c  = A - B;
    assign shamt_c = B[SHW-1:0];
    assign slt_c   = $signed(A) < $signed(B);
    assign sltu_c  = A < B;

    // Single-cycle operations and overflow detection
    always_comb begin
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        case (ALUControl)
            OP_AND:  alu_res_c = A & B;
            OP_OR:   alu_res_c = A | B;
            OP_XOR:  alu_res_c = A ^ B;
            OP_ADD: begin
                alu_res_c = sum_c;
                alu_ovf_c = (A[WIDTH-1] == B[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = (A[WIDTH-1] != B[WIDTH-1]) && (diff_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  alu_res_c = WIDTH'(slt_c);
            OP_SLTU: alu_res_c = WIDTH'(sltu_c);
            OP_SLL:  alu_res_c = A << shamt_c;
            OP_SRL:  alu_res_c = A >> shamt_c;
            OP_SRA:  alu_res_c = $unsigned($signed(A) >>> shamt_c);
            default: alu_res_c = '0;
        endcase
    end

    // One shift-add (LSB first) or restoring-divide (MSB first) step
    always_comb begin
        mul_acc_next_c = op_b_q[0] ? (acc_q + op_a_q) : acc_q;
        div_shift_c    = {acc_q, op_a_q[WIDTH-1]};
        div_ge_c       = (div_shift_c >= {1'b0, op_b_q});
        // Partial remainder stays below the divisor, so the low WIDTH bits suffice
        div_sub_c      = div_shift_c[WIDTH-1:0] - op_b_q;
        div_rem_next_c = div_ge_c ? div_sub_c : div_shift_c[WIDTH-1:0];
        div_q_next_c   = {op_a_q[WIDTH-2:0], div_ge_c};
        if (op_q == OP_MUL) begin
            iter_res_c = mul_acc_next_c;
        end else if (op_q == OP_DIVU) begin
            iter_res_c = div_q_next_c;
        end else begin
            iter_res_c = div_rem_next_c;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (InValid) begin
                    state_next = is_iter_c ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last_step_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        result_d    = Result;
        zero_d      = Zero;
        ovf_d       = Overflow;
        in_ready_d  = (state_next == IDLE);
        out_valid_d = (state_next == DONE);
        case (state)
            IDLE: begin
                if (InValid && !is_iter_c) begin
                    result_d = alu_res_c;
                    zero_d   = (alu_res_c == '0);
                    ovf_d    = alu_ovf_c;
                end
            end
            BUSY: begin
                if (last_step_c) begin
                    result_d = iter_res_c;
                    zero_d   = (iter_res_c == '0);
                    ovf_d    = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs; InReady comes out of reset already high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Result   <= '0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
            OutValid <= 1'b0;
            InReady  <= 1'b1;
        end else begin
            Result   <= result_d;
            Zero     <= zero_d;
            Overflow <= ovf_d;
            OutValid <= out_valid_d;
            InReady  <= in_ready_d;
        end
    end

    // Iterative operand latch and step counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a_q <= '0;
            op_b_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
        end else if (accept_c && is_iter_c) begin
            op_a_q <= A;
            op_b_q <= B;
            acc_q  <= '0;
            cnt_q  <= '0;
            op_q   <= ALUControl;
        end else if (state == BUSY) begin
            cnt_q <= cnt_q + SHW'(1);
            if (op_q == OP_MUL) begin
                acc_q  <= mul_acc_next_c;
                op_a_q <= op_a_q << 1;
                op_b_q <= op_b_q >> 1;
            end else begin
                acc_q  <= div_rem_next_c;
                op_a_q <= div_q_next_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table-driven checks of alu_seq in three configurations
// (64-bit, 16-bit, 64-bit without MUL/DIV), plus backpressure and reset sequences.
module tb_alu_seq;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;
    localparam logic [3:0] OP_BAD  = 4'b1111;
    localparam logic [3:0] OP_BAD5 = 4'b0101;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a, b;
    logic [3:0]  ctl;
    logic        in_valid;
    logic        out_ready;
    int          sel;

    logic [63:0] r0, r2;
    logic [15:0] r1;
    logic [2:0]  z, ovf, ov, ir;

    logic [63:0] m_res;
    logic        m_z, m_ovf, m_ov, m_ir;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(64), .ENABLE_MULDIV(1'b1)) dut64 (
        .clk(clk), .reset(reset), .A(a), .B(b), .ALUControl(ctl),
        .InValid(in_valid && (sel == 0)), .InReady(ir[0]), .Result(r0),
        .Zero(z[0]), .Overflow(ovf[0]), .OutValid(ov[0]), .OutReady(out_ready)
    );

    alu_seq #(.WIDTH(16), .ENABLE_MULDIV(1'b1)) dut16 (
        .clk(clk), .reset(reset), .A(a[15:0]), .B(b[15:0]), .ALUControl(ctl),
        .InValid(in_valid && (sel == 1)), .InReady(ir[1]), .Result(r1),
        .Zero(z[1]), .Overflow(ovf[1]), .OutValid(ov[1]), .OutReady(out_ready)
    );

    alu_seq #(.WIDTH(64), .ENABLE_MULDIV(1'b0)) dutnm (
        .clk(clk), .reset(reset), .A(a), .B(b), .ALUControl(ctl),
        .InValid(in_valid && (sel == 2)), .InReady(ir[2]), .Result(r2),
        .Zero(z[2]), .Overflow(ovf[2]), .OutValid(ov[2]), .OutReady(out_ready)
    );

    // Route the selected instance's outputs to the checker
    always_comb begin
        case (sel)
            1:       begin m_res = {48'h0, r1}; m_z = z[1]; m_ovf = ovf[1]; m_ov = ov[1]; m_ir = ir[1]; end
            2:       begin m_res = r2;          m_z = z[2]; m_ovf = ovf[2]; m_ov = ov[2]; m_ir = ir[2]; end
            default: begin m_res = r0;          m_z = z[0]; m_ovf = ovf[0]; m_ov = ov[0]; m_ir = ir[0]; end
        endcase
    end

    typedef struct {
        int          sel;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        z;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op from a negedge; lat is the edge (counted from accept) at
    // which the consumer first sees OutValid. Retires with OutReady high.
    task automatic run_op(input int s, input logic [3:0] op, input logic [63:0] x,
                          input logic [63:0] y, output logic [63:0] res,
                          output logic rz, output logic rovf, output int lat,
                          output logic ir_seen);
        sel      = s;
        a        = x;
        b        = y;
        ctl      = op;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        ir_seen  = 1'b0;
        while (!m_ov && lat < 200) begin
            if (m_ir) ir_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (m_ir) ir_seen = 1'b1;
        res  = m_res;
        rz   = m_z;
        rovf = m_ovf;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] res;
        logic        rz, rovf, irs;
        int          lat;

        //           sel op       A                       B                       Result                  Z     O     lat
        vecs.push_back('{0, OP_ADD,  64'd100,                64'd50,                 64'd150,                1'b0, 1'b0, 1});
        vecs.push_back('{0, OP_SUB,  64'h1234_5678_1234_5678, 64'h1234_5678_1234_5678, 64'd0,                  1'b1, 1'b0, 1});
        vecs.push_back('{0, OP_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                  64'h8000_0000_0000_0000, 1'b0, 1'b1, 1});
        vecs.push_back('{0, OP_SRA,  64'h8000_0000_0000_0000, 64'd4,                  64'hF800_0000_0000_0000, 1'b0, 1'b0, 1});
        vecs.push_back('{0, OP_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'd1,                  1'b0, 1'b0, 1});
        vecs.push_back('{0, OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'd0,                  1'b1, 1'b0, 1});
        vecs.push_back('{0, OP_AND,  64'hF0F0,               64'h0FF0,               64'h00F0,               1'b0, 1'b0, 1});
        vecs.push_back('{0, OP_OR,   64'hF0F0,               64'h0FF0,               64'hFFF0,               1'b0, 1'b0, 1});
        vecs.push_back('{0, OP_XOR,  64'hF0F0,               64'h0FF0,               64'hFF00,               1'b0, 1'b0, 1});
        vecs.push_back('{0, OP_SLL,  64'd1,                  64'd63,                 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1});
        vecs.push_back('{0, OP_SLL,  64'd3,                  64'd65,                 64'd6,                  1'b0, 1'b0, 1});
        vecs.push_back('{0, OP_SRL,  64'h8000_0000_0000_0000, 64'd63,                 64'd1,                  1'b0, 1'b0, 1});
        vecs.push_back('{0, OP_SUB,  64'h8000_0000_0000_0000, 64'd1,                  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1});
        vecs.push_back('{0, OP_SUB,  64'd5,                  64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{0, OP_MUL,  64'h1_0000_0001,        64'd3,                  64'h3_0000_0003,        1'b0, 1'b0, 65});
        vecs.push_back('{0, OP_MUL,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  1'b0, 1'b0, 65});
        vecs.push_back('{0, OP_DIVU, 64'd100,                64'd7,                  64'd14,                 1'b0, 1'b0, 65});
        vecs.push_back('{0, OP_REMU, 64'd100,                64'd7,                  64'd2,                  1'b0, 1'b0, 65});
        vecs.push_back('{0, OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 65});
        vecs.push_back('{0, OP_DIVU, 64'd33,                 64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 65});
        vecs.push_back('{0, OP_REMU, 64'd33,                 64'd0,                  64'd33,                 1'b0, 1'b0, 65});
        vecs.push_back('{0, OP_BAD,  64'd5,                  64'd6,                  64'd0,                  1'b1, 1'b0, 1});
        vecs.push_back('{0, OP_BAD5, 64'd5,                  64'd6,                  64'd0,                  1'b1, 1'b0, 1});
        vecs.push_back('{1, OP_ADD,  64'd100,                64'd50,                 64'd150,                1'b0, 1'b0, 1});
        vecs.push_back('{1, OP_SUB,  64'h1234,               64'h1234,               64'd0,                  1'b1, 1'b0, 1});
        vecs.push_back('{1, OP_ADD,  64'h7FFF,               64'd1,                  64'h8000,               1'b0, 1'b1, 1});
        vecs.push_back('{1, OP_MUL,  64'h0101,               64'd3,                  64'h0303,               1'b0, 1'b0, 17});
        vecs.push_back('{1, OP_DIVU, 64'd100,                64'd7,                  64'd14,                 1'b0, 1'b0, 17});
        vecs.push_back('{1, OP_REMU, 64'd100,                64'd7,                  64'd2,                  1'b0, 1'b0, 17});
        vecs.push_back('{1, OP_DIVU, 64'd33,                 64'd0,                  64'hFFFF,               1'b0, 1'b0, 17});
        vecs.push_back('{2, OP_ADD,  64'd100,                64'd50,                 64'd150,                1'b0, 1'b0, 1});
        vecs.push_back('{2, OP_SUB,  64'h1234_5678_1234_5678, 64'h1234_5678_1234_5678, 64'd0,                  1'b1, 1'b0, 1});
        vecs.push_back('{2, OP_MUL,  64'h1_0000_0001,        64'd3,                  64'd0,                  1'b1, 1'b0, 1});
        vecs.push_back('{2, OP_DIVU, 64'd100,                64'd7,                  64'd0,                  1'b1, 1'b0, 1});
        vecs.push_back('{2, OP_REMU, 64'd100,                64'd7,                  64'd0,                  1'b1, 1'b0, 1});

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = 0;
        a         = '0;
        b         = '0;
        ctl       = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_result",   m_res, 64'd0);
        check("reset_zero",     64'(m_z), 64'd0);
        check("reset_overflow", 64'(m_ovf), 64'd0);
        check("reset_outvalid", 64'(m_ov), 64'd0);
        check("reset_inready",  64'(m_ir), 64'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, res, rz, rovf, lat, irs);
            check($sformatf("v%0d_result", i),   res, vecs[i].res);
            check($sformatf("v%0d_zero", i),     64'(rz), 64'(vecs[i].z));
            check($sformatf("v%0d_overflow", i), 64'(rovf), 64'(vecs[i].ovf));
            check($sformatf("v%0d_latency", i),  64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_inready_low", i), 64'(irs), 64'd0);
            check($sformatf("v%0d_inready_back", i), 64'(m_ir), 64'd1);
        end

        // Backpressure: hold OutReady low, pulse InValid while DONE
        sel       = 0;
        out_ready = 1'b0;
        a         = 64'd10;
        b         = 64'd20;
        ctl       = OP_ADD;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp%0d_result", i),   m_res, 64'd30);
            check($sformatf("bp%0d_outvalid", i), 64'(m_ov), 64'd1);
            check($sformatf("bp%0d_inready", i),  64'(m_ir), 64'd0);
            if (i == 4) begin
                a        = 64'd1;
                b        = 64'd1;
                in_valid = 1'b1;
            end
            if (i == 5) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_retire_inready",  64'(m_ir), 64'd1);
        check("bp_retire_outvalid", 64'(m_ov), 64'd0);
        repeat (3) @(negedge clk);
        check("bp_pulse_ignored", 64'(m_ov), 64'd0);

        // Reset in the middle of a DIVU
        a        = 64'd1000;
        b        = 64'd7;
        ctl      = OP_DIVU;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_busy_inready", 64'(m_ir), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy_result",   m_res, 64'd0);
        check("rst_busy_zero",     64'(m_z), 64'd0);
        check("rst_busy_overflow", 64'(m_ovf), 64'd0);
        check("rst_busy_outvalid", 64'(m_ov), 64'd0);
        check("rst_busy_inready",  64'(m_ir), 64'd1);
        run_op(0, OP_ADD, 64'd2, 64'd2, res, rz, rovf, lat, irs);
        check("post_rst_add_result",  res, 64'd4);
        check("post_rst_add_latency", 64'(lat), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
